// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic overflow/exception unit.
// Op encodings match the in_op port; codes match out_code/exc_code.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDI = 2'b01,
        OP_SUB  = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_ADD  = 3'd1;
    localparam logic [2:0] CODE_ADDI = 3'd2;
    localparam logic [2:0] CODE_SUB  = 3'd3;

    function automatic logic [2:0] op_code(input op_e op);
        logic [2:0] code;
        unique case (op)
            OP_ADD:  code = CODE_ADD;
            OP_ADDI: code = CODE_ADDI;
            OP_SUB:  code = CODE_SUB;
            OP_NONE: code = CODE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ovf_detect.sv
// Combinational overflow detector for add/sub results,
// signed or unsigned, at any datapath width.
module ovf_detect
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic sa;
    logic sb;
    logic sr;
    logic add_ovf;
    logic sub_ovf;

    assign sa = a[WIDTH-1];
    assign sb = b[WIDTH-1];
    assign sr = result[WIDTH-1];

    // Unsigned add wraps iff the sum is below an operand; sub borrows iff a < b.
    always_comb begin
        add_ovf = is_unsigned ? (result < a) : ((sa == sb) && (sr != sa));
        sub_ovf = is_unsigned ? (a < b) : ((sa != sb) && (sr != sa));
        ovf = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDI: ovf = add_ovf;
            OP_SUB:          ovf = sub_ovf;
            OP_NONE:         ovf = 1'b0;
        endcase
    end

endmodule

// File: rtl/arith_exc_unit.sv
// Two-stage arithmetic overflow checker with a single-entry
// pending-exception register and sticky overflow status.
module arith_exc_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic             in_unsigned,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_result,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_ovf,
    output logic [2:0]       out_code,
    output logic [TAG_W-1:0] out_tag,
    output logic             exc_valid,
    output logic [2:0]       exc_code,
    output logic [TAG_W-1:0] exc_tag,
    input  logic             exc_ack,
    output logic             sticky_ovf,
    output logic             exc_lost,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clear_sticky
);

    logic             s1_valid;
    op_e              s1_op;
    logic             s1_uns;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_res;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_ovf;

    logic             s2_valid;
    logic             s2_ovf;
    logic [2:0]       s2_code;
    logic [TAG_W-1:0] s2_tag;

    logic             ovf_ev;
    logic             take_exc;

    ovf_detect #(
        .WIDTH(WIDTH)
    ) u_detect (
        .op          (s1_op),
        .is_unsigned (s1_uns),
        .a           (s1_a),
        .b           (s1_b),
        .result      (s1_res),
        .ovf         (s1_ovf)
    );

    assign ovf_ev   = out_valid & out_ovf;
    assign take_exc = ovf_ev & (~exc_valid | exc_ack);

    // Operand capture; qualified by s1_valid, so no reset needed.
    always_ff @(posedge clock) begin
        s1_op  <= op_e'(in_op);
        s1_uns <= in_unsigned;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_res <= in_result;
        s1_tag <= in_tag;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_code    <= CODE_NONE;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_ovf    <= 1'b0;
            out_code   <= CODE_NONE;
            out_tag    <= '0;
            exc_valid  <= 1'b0;
            exc_code   <= CODE_NONE;
            exc_tag    <= '0;
            sticky_ovf <= 1'b0;
            exc_lost   <= 1'b0;
            ovf_count  <= '0;
        end else begin
            s1_valid <= in_valid & ~flush;
            s2_valid <= s1_valid & ~flush;
            s2_ovf   <= s1_valid & ~flush & s1_ovf;
            s2_code  <= s1_ovf ? op_code(s1_op) : CODE_NONE;
            s2_tag   <= s1_tag;

            out_valid <= s2_valid;
            out_ovf   <= s2_valid & s2_ovf;
            out_code  <= (s2_valid & s2_ovf) ? s2_code : CODE_NONE;
            out_tag   <= s2_tag;

            if (take_exc) begin
                exc_valid <= 1'b1;
                exc_code  <= out_code;
                exc_tag   <= out_tag;
            end else if (exc_valid && exc_ack) begin
                exc_valid <= 1'b0;
            end

            if (clear_sticky) begin
                sticky_ovf <= 1'b0;
                exc_lost   <= 1'b0;
                ovf_count  <= '0;
            end else begin
                if (ovf_ev) begin
                    sticky_ovf <= 1'b1;
                    if (ovf_count != '1)
                        ovf_count <= ovf_count + 1'b1;
                end
                if (ovf_ev && exc_valid && !exc_ack)
                    exc_lost <= 1'b1;
            end
        end
    end

endmodule
